// File: rtl/logic_result_display.sv
// Result-word display stage: accepts one {OF, value} word per handshake, holds it for a
// minimum time, and scans it onto two active-low seven-segment digits plus a blinking OF LED.
module logic_result_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_valid,
  input  logic [8:0] res_word,
  input  logic [1:0] res_mode,
  output logic       res_ready,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       ovf_led
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SHOW  = 2'd1,
    ST_LIVE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [8:0]      word_q, word_d;
  logic [1:0]      mode_q, mode_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [RW-1:0]   refresh_cnt_q, refresh_cnt_d;
  logic            scan_idx_q, scan_idx_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic            accept_s;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign accept_s = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) state_d = ST_SHOW;
        else          state_d = ST_EMPTY;
      end
      ST_SHOW: begin
        if (hold_cnt_q == HOLD_LAST) state_d = ST_LIVE;
        else                         state_d = ST_SHOW;
      end
      ST_LIVE: begin
        if (accept_s) state_d = ST_SHOW;
        else          state_d = ST_LIVE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Outputs depend only on registered state, so there is no input-to-output path.
  always_comb begin
    res_ready = 1'b0;
    seg       = 7'h7F;
    an        = scan_idx_q ? 2'b01 : 2'b10;
    ovf_led   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        res_ready = 1'b1;
        seg       = 7'h7F;
        ovf_led   = 1'b0;
      end
      ST_SHOW, ST_LIVE: begin
        res_ready = (state_q == ST_LIVE);
        if (!scan_idx_q)            seg = hex_seg(word_q[3:0]);
        else if (mode_q == 2'b11)   seg = hex_seg(word_q[7:4]);
        else                        seg = 7'h7F;
        ovf_led = word_q[8] && !blink_phase_q;
      end
      default: begin
        res_ready = 1'b0;
        seg       = 7'h7F;
        ovf_led   = 1'b0;
      end
    endcase
  end

  always_comb begin
    word_d        = word_q;
    mode_d        = mode_q;
    hold_cnt_d    = {HW{1'b0}};
    refresh_cnt_d = refresh_cnt_q;
    scan_idx_d    = scan_idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if (accept_s) begin
      word_d = res_word;
      mode_d = res_mode;
    end else begin
      word_d = word_q;
      mode_d = mode_q;
    end

    if (state_q == ST_SHOW && hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + HW'(1);
    else                                               hold_cnt_d = {HW{1'b0}};

    // Scan runs freely in every state; only rst restarts it.
    if (refresh_cnt_q == REFRESH_LAST) begin
      refresh_cnt_d = {RW{1'b0}};
      scan_idx_d    = ~scan_idx_q;
    end else begin
      refresh_cnt_d = refresh_cnt_q + RW'(1);
      scan_idx_d    = scan_idx_q;
    end

    // Phase 0 is the lit half, so a fresh OF capture shows the LED at once.
    if (accept_s) begin
      blink_cnt_d   = {BW{1'b0}};
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = {BW{1'b0}};
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BW'(1);
      blink_phase_d = blink_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q        <= 9'h000;
      mode_q        <= 2'b00;
      hold_cnt_q    <= {HW{1'b0}};
      refresh_cnt_q <= {RW{1'b0}};
      scan_idx_q    <= 1'b0;
      blink_cnt_q   <= {BW{1'b0}};
      blink_phase_q <= 1'b0;
    end else begin
      word_q        <= word_d;
      mode_q        <= mode_d;
      hold_cnt_q    <= hold_cnt_d;
      refresh_cnt_q <= refresh_cnt_d;
      scan_idx_q    <= scan_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

endmodule

// File: tb/tb_logic_result_display.sv
// Directed bench for logic_result_display with short refresh/hold/blink periods.
module tb_logic_result_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       res_valid;
  logic [8:0] res_word;
  logic [1:0] res_mode;
  logic       res_ready;
  logic [6:0] seg;
  logic [1:0] an;
  logic       ovf_led;

  int tests = 0;
  int fails = 0;
  int k     = 0;

  typedef struct {
    logic [8:0] word;
    logic [1:0] mode;
    logic [6:0] d0;
    logic [6:0] d1;
  } vec_t;

  vec_t vecs [7];

  logic_result_display #(
    .REFRESH_DIV(4),
    .HOLD_CYCLES(8),
    .BLINK_DIV  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .res_valid(res_valid),
    .res_word (res_word),
    .res_mode (res_mode),
    .res_ready(res_ready),
    .seg      (seg),
    .an       (an),
    .ovf_led  (ovf_led)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
    k = k + 1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, k, got, exp);
    end
  endtask

  // k counts cycles since the last reset edge; each digit owns 4 consecutive cycles.
  task automatic chk_disp(input logic [6:0] d0, input logic [6:0] d1,
                          input logic rdy, input logic ovf);
    logic idx;
    idx = ((k / 4) % 2) != 0;
    chk("an", {6'd0, an}, idx ? 8'h01 : 8'h02);
    chk("seg", {1'b0, seg}, idx ? {1'b0, d1} : {1'b0, d0});
    chk("ready", {7'd0, res_ready}, {7'd0, rdy});
    chk("ovf_led", {7'd0, ovf_led}, {7'd0, ovf});
  endtask

  function automatic logic ovf_exp(input logic of, input int j);
    return of && (((j - 1) / 3) % 2 == 0);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    k = 0;
  endtask

  // One-cycle valid pulse, then hold period checks, then `extra` LIVE cycles.
  task automatic run_word(input logic [8:0] w, input logic [1:0] m,
                          input logic [6:0] d0, input logic [6:0] d1, input int extra);
    chk("ready_pre", {7'd0, res_ready}, 8'h01);
    res_valid = 1'b1;
    res_word  = w;
    res_mode  = m;
    step();
    res_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      chk_disp(d0, d1, 1'b0, ovf_exp(w[8], j));
      step();
    end
    chk_disp(d0, d1, 1'b1, ovf_exp(w[8], 9));
    for (int j = 10; j < 10 + extra; j++) begin
      step();
      chk_disp(d0, d1, 1'b1, ovf_exp(w[8], j));
    end
  endtask

  initial begin
    vecs[0] = '{word: 9'h00A, mode: 2'b00, d0: 7'h08, d1: 7'h7F};
    vecs[1] = '{word: 9'h1C3, mode: 2'b11, d0: 7'h30, d1: 7'h46};
    vecs[2] = '{word: 9'h05A, mode: 2'b11, d0: 7'h08, d1: 7'h12};
    vecs[3] = '{word: 9'h0F7, mode: 2'b01, d0: 7'h78, d1: 7'h7F};
    vecs[4] = '{word: 9'h19E, mode: 2'b10, d0: 7'h06, d1: 7'h7F};
    vecs[5] = '{word: 9'h0D1, mode: 2'b11, d0: 7'h79, d1: 7'h21};
    vecs[6] = '{word: 9'h1B4, mode: 2'b11, d0: 7'h19, d1: 7'h03};

    res_valid = 1'b0;
    res_word  = 9'h000;
    res_mode  = 2'b00;
    do_reset();
    do_reset();
    rst = 1'b0;

    // Idle after reset: blank, ready, LED off, anodes alternate every 4 cycles.
    for (int i = 0; i < 12; i++) begin
      chk_disp(7'h7F, 7'h7F, 1'b1, 1'b0);
      step();
    end

    foreach (vecs[i]) begin
      run_word(vecs[i].word, vecs[i].mode, vecs[i].d0, vecs[i].d1, 2);
      step();
    end

    // Back-to-back: valid held high, second word taken on the first LIVE cycle.
    chk("ready_b2b", {7'd0, res_ready}, 8'h01);
    res_valid = 1'b1;
    res_word  = 9'h005;
    res_mode  = 2'b00;
    step();
    res_word = 9'h006;
    for (int j = 1; j <= 8; j++) begin
      chk_disp(7'h12, 7'h7F, 1'b0, 1'b0);
      step();
    end
    chk_disp(7'h12, 7'h7F, 1'b1, 1'b0);
    step();
    res_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      chk_disp(7'h02, 7'h7F, 1'b0, 1'b0);
      step();
    end
    chk_disp(7'h02, 7'h7F, 1'b1, 1'b0);
    step();

    // Reset at hold count 4 while a new word is pending; reset also wins in EMPTY.
    res_valid = 1'b1;
    res_word  = 9'h1C3;
    res_mode  = 2'b11;
    step();
    res_word = 9'h0A7;
    for (int j = 1; j <= 5; j++) begin
      chk_disp(7'h30, 7'h46, 1'b0, ovf_exp(1'b1, j));
      if (j < 5) step();
    end
    do_reset();
    chk_disp(7'h7F, 7'h7F, 1'b1, 1'b0);
    do_reset();
    chk_disp(7'h7F, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
    step();
    res_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      chk_disp(7'h78, 7'h08, 1'b0, 1'b0);
      step();
    end
    chk_disp(7'h78, 7'h08, 1'b1, 1'b0);
    step();

    // OF word then non-OF word captured in LIVE: LED must drop and stay dark.
    run_word(9'h1FF, 2'b11, 7'h0E, 7'h0E, 1);
    step();
    run_word(9'h012, 2'b00, 7'h24, 7'h7F, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
